uart_tx_fsm: RTL and testbench
==============================

Name: uart_tx_fsm

Overview:
- UART transmitter for the system's serial link; the transmit-side counterpart of the UART_RX datapath.
- Accepts a parallel byte on a single-cycle valid strobe and serialises it onto TX_OUT.
- Frame format: start bit, 8 data bits LSB first, optional parity bit, one stop bit.
- Bit period is programmable in clk cycles. One module contains the FSM, bit-period counter, bit counter, shift register and parity generator.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- PRESC_WIDTH, 5, width of the prescale input.

Ports:
- clk  input  1  transmit clock.
- RST  input  1  asynchronous, active-low reset.
- P_DATA  input  DATA_WIDTH  byte to send; sampled only on the accept edge.
- Data_Valid  input  1  request strobe; honoured only in IDLE.
- PAR_EN  input  1  1 = insert parity bit; latched on accept.
- PAR_TYP  input  1  0 = even, 1 = odd; latched on accept.
- prescale  input  PRESC_WIDTH  clk cycles per bit; latched on accept; 0 is treated as 1.
- TX_OUT  output  1  serial line, registered, idles high.
- busy  output  1  high while a frame is in progress, registered.

Behaviour:
- Reset (async, RST=0): state=IDLE, TX_OUT=1, busy=0, all counters and shift register cleared. Reset asserted mid-frame aborts the frame immediately; no partial frame is resumed after release.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, busy=0.
  - On a clk edge with Data_Valid=1: latch P_DATA, PAR_EN, PAR_TYP and prescale (0→1).
  - Compute par_bit = ^P_DATA for even, ~^P_DATA for odd.
  - At that same edge: state→START, TX_OUT←0, busy←1.
- Bit timing:
  - Edge counter runs 0..presc_l-1 in every non-IDLE state.
  - Each bit is driven for exactly presc_l cycles.
  - State and bit transitions occur at the edge where edge_cnt==presc_l-1, and the counter wraps to 0.
- START: TX_OUT=0 for presc_l cycles → DATA. TX_OUT←data bit 0.
- DATA:
  - Bits shifted out LSB first.
  - Bit counter advances 0..7 at each bit-end edge.
  - After bit 7 ends: PAR_EN_l=1 → PARITY (TX_OUT←par_bit); otherwise → STOP (TX_OUT←1).
- PARITY: TX_OUT=par_bit for presc_l cycles → STOP, TX_OUT←1.
- STOP: TX_OUT=1 for presc_l cycles, then at the bit-end edge: state→IDLE, busy←0.
- Frame length, from accept edge to busy fall: 10*presc_l cycles without parity, 11*presc_l with parity.
- Data_Valid while busy=1 is ignored; there is no queueing. Changes to P_DATA, PAR_EN, PAR_TYP or prescale mid-frame have no effect.
- Back-to-back frames: with Data_Valid held high, the next accept occurs on the first edge in IDLE. The line is therefore high for presc_l+1 cycles between frames (minimum inter-frame gap of 1 cycle beyond the stop bit).
- TX_OUT is driven only from a flop, so it is glitch-free.
- Illegal or unused state encodings → IDLE on the next edge with TX_OUT=1, busy=0.

Test Plan:
- prescale=1, PAR_EN=0, P_DATA=0xA5, Data_Valid for 1 cycle → TX_OUT per cycle = 0,1,0,1,0,0,1,0,1,1; busy high exactly 10 cycles.
- prescale=1, PAR_EN=1, PAR_TYP=0, P_DATA=0xA5 → parity bit 0, 11-bit frame; repeat with PAR_TYP=1 → parity bit 1.
- prescale=8, PAR_EN=1, PAR_TYP=1, P_DATA=0x01 → every bit is 8 cycles wide, parity bit 0, busy high 88 cycles.
- Data_Valid pulsed with P_DATA=0x3C mid-frame, and P_DATA changed during the frame → original byte transmitted unchanged, no second frame.
- Data_Valid held high, prescale=4, bytes 0x55 then 0xAA → two complete frames; line high for exactly 5 cycles between the two stop/start boundaries.
- RST pulsed low during DATA bit 3 → TX_OUT=1 and busy=0 immediately (asynchronously); new frame 0xFF after release is transmitted correctly.

Source files
------------

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: serial transmitter for the system link.
// Frame: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// The bit period is presc_l clk cycles; the prescale value is captured when a byte is accepted.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | line high, waiting for Data_Valid
// START  | driving the start bit (low) for one bit period
// DATA   | shifting data bits out LSB first, bit_cnt selects the bit
// PARITY | driving the latched parity bit (only when PAR_EN was set)
// STOP   | driving the stop bit (high); busy drops at its end
module uart_tx_fsm #(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   RST,
    input  logic [DATA_WIDTH-1:0]  P_DATA,
    input  logic                   Data_Valid,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    input  logic [PRESC_WIDTH-1:0] prescale,
    output logic                   TX_OUT,
    output logic                   busy
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0]   LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [PRESC_WIDTH-1:0] PRESC_ONE = PRESC_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                 state;
    logic [PRESC_WIDTH-1:0] presc_l;
    logic [PRESC_WIDTH-1:0] bit_tmr;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [DATA_WIDTH-1:0]  shift_reg;
    logic                   par_en_l;
    logic                   par_l;
    logic [PRESC_WIDTH-1:0] presc_in;
    logic                   bit_end;

    // A prescale of zero would give a zero-length bit, so it is promoted to one.
    assign presc_in = (prescale == '0) ? PRESC_ONE : prescale;

    // The bit timer counts down from presc_l-1; reaching zero marks the last cycle of a bit.
    assign bit_end = (bit_tmr == '0);

    // Frame sequencer: state, bit timer, bit counter, shift register and registered line outputs.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            presc_l   <= PRESC_ONE;
            bit_tmr   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_en_l  <= 1'b0;
            par_l     <= 1'b0;
            TX_OUT    <= 1'b1;
            busy      <= 1'b0;
        end else begin
            // Every bit in a frame lasts presc_l cycles; the timer reloads at each bit end.
            if (state != IDLE) begin
                bit_tmr <= bit_end ? (presc_l - PRESC_ONE) : (bit_tmr - PRESC_ONE);
            end

            case (state)
                IDLE: begin
                    TX_OUT  <= 1'b1;
                    busy    <= 1'b0;
                    bit_tmr <= '0;
                    bit_cnt <= '0;
                    if (Data_Valid) begin
                        shift_reg <= P_DATA;
                        par_en_l  <= PAR_EN;
                        par_l     <= PAR_TYP ? ~^P_DATA : ^P_DATA;
                        presc_l   <= presc_in;
                        bit_tmr   <= presc_in - PRESC_ONE;
                        state     <= START;
                        TX_OUT    <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        state     <= DATA;
                        bit_cnt   <= '0;
                        TX_OUT    <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == LAST_BIT) begin
                            if (par_en_l) begin
                                state  <= PARITY;
                                TX_OUT <= par_l;
                            end else begin
                                state  <= STOP;
                                TX_OUT <= 1'b1;
                            end
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            TX_OUT    <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        state  <= STOP;
                        TX_OUT <= 1'b1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        state  <= IDLE;
                        TX_OUT <= 1'b1;
                        busy   <= 1'b0;
                    end
                end

                default: begin
                    // Unused encodings recover straight to an idle line.
                    state   <= IDLE;
                    bit_tmr <= '0;
                    bit_cnt <= '0;
                    TX_OUT  <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Testbench for uart_tx_fsm: stimulus pushes hand-built expected frames into a queue,
// a monitor pops one per frame start and checks the line cycle by cycle.
module tb_uart_tx_fsm;

    logic       clk = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [4:0] prescale = 5'd0;
    logic       TX_OUT;
    logic       busy;

    uart_tx_fsm #(.DATA_WIDTH(8), .PRESC_WIDTH(5)) dut (
        .clk        (clk),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .prescale   (prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // bits[i] is the i-th line value of the frame, start bit first
    typedef struct {
        logic [10:0] bits;
        int          nbits;
        int          presc;
        bit          b2b;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [10:0] bits, input int nbits, input int presc, input bit b2b);
        exp_t e;
        e.bits  = bits;
        e.nbits = nbits;
        e.presc = presc;
        e.b2b   = b2b;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int max_cycles);
        int n;
        n = 0;
        while (busy && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done", 32'(busy), 32'd0);
    endtask

    task automatic send(input logic [7:0] data, input logic pen, input logic ptyp,
                        input logic [4:0] presc, input logic [10:0] frame,
                        input int nbits, input int exp_presc);
        push(frame, nbits, exp_presc, 1'b0);
        P_DATA     = data;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        prescale   = presc;
        Data_Valid = 1'b1;
        @(negedge clk);
        Data_Valid = 1'b0;
        wait_done(200);
        repeat (3) @(negedge clk);
    endtask

    // Monitor: a busy rise marks an accept; the frame is then checked every cycle.
    initial begin : monitor
        logic prev_busy;
        bit   b2b_pending;
        bit   aborted;
        exp_t e;
        prev_busy   = 1'b0;
        b2b_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (b2b_pending) begin
                b2b_pending = 1'b0;
                chk("b2b_restart", 32'(busy), 32'd1);
            end
            if (RST && busy && !prev_busy) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got busy rise expected none at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    aborted = 1'b0;
                    for (int c = 0; c < e.nbits * e.presc; c++) begin
                        if (c > 0) @(negedge clk);
                        if (!RST) begin
                            aborted = 1'b1;
                            break;
                        end
                        chk("tx_bit", 32'(TX_OUT), 32'(e.bits[c / e.presc]));
                        chk("busy_in_frame", 32'(busy), 32'd1);
                    end
                    if (!aborted) begin
                        @(negedge clk);
                        if (RST) begin
                            chk("busy_fall", 32'(busy), 32'd0);
                            chk("line_idle", 32'(TX_OUT), 32'd1);
                            b2b_pending = e.b2b;
                        end
                    end
                end
            end
            prev_busy = busy;
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got no finish expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        RST = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx", 32'(TX_OUT), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        RST = 1'b1;
        @(negedge clk);

        // 0xA5 no parity: line 0,1,0,1,0,0,1,0,1,1
        send(8'hA5, 1'b0, 1'b0, 5'd1, {2'b11, 8'hA5, 1'b0}, 10, 1);
        // 0xA5 has four ones: even parity 0, odd parity 1
        send(8'hA5, 1'b1, 1'b0, 5'd1, {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 1);
        send(8'hA5, 1'b1, 1'b1, 5'd1, {1'b1, 1'b1, 8'hA5, 1'b0}, 11, 1);
        // 0x01 odd parity -> 0, 8-cycle bits, 88 cycles busy
        send(8'h01, 1'b1, 1'b1, 5'd8, {1'b1, 1'b0, 8'h01, 1'b0}, 11, 8);
        // prescale 0 behaves as 1; 0x3C even parity -> 0
        send(8'h3C, 1'b1, 1'b0, 5'd0, {1'b1, 1'b0, 8'h3C, 1'b0}, 11, 1);

        // Mid-frame request and input changes must not disturb 0x96
        push({2'b11, 8'h96, 1'b0}, 10, 2, 1'b0);
        P_DATA     = 8'h96;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        prescale   = 5'd2;
        Data_Valid = 1'b1;
        @(negedge clk);
        Data_Valid = 1'b0;
        repeat (7) @(negedge clk);
        P_DATA     = 8'h3C;
        PAR_EN     = 1'b1;
        prescale   = 5'd1;
        Data_Valid = 1'b1;
        @(negedge clk);
        Data_Valid = 1'b0;
        repeat (3) @(negedge clk);
        P_DATA = 8'h00;
        wait_done(200);
        repeat (6) @(negedge clk);
        chk("no_second_frame_q", 32'(exp_q.size()), 32'd0);

        // Back-to-back with Data_Valid held: 0x55 then 0xAA, prescale 4
        push({2'b11, 8'h55, 1'b0}, 10, 4, 1'b1);
        push({2'b11, 8'hAA, 1'b0}, 10, 4, 1'b0);
        P_DATA     = 8'h55;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        prescale   = 5'd4;
        Data_Valid = 1'b1;
        @(negedge clk);
        P_DATA = 8'hAA;
        repeat (41) @(negedge clk);
        Data_Valid = 1'b0;
        wait_done(200);
        repeat (3) @(negedge clk);

        // Reset during data bit 3 of 0xF0 (bit 3 is 0, so the line must jump high)
        push({2'b11, 8'hF0, 1'b0}, 10, 2, 1'b0);
        P_DATA     = 8'hF0;
        PAR_EN     = 1'b0;
        prescale   = 5'd2;
        Data_Valid = 1'b1;
        @(negedge clk);
        Data_Valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_reset_bit3", 32'(TX_OUT), 32'd0);
        #2;
        RST = 1'b0;
        #1;
        chk("async_reset_tx", 32'(TX_OUT), 32'd1);
        chk("async_reset_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        RST = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("post_reset_tx", 32'(TX_OUT), 32'd1);
        send(8'hFF, 1'b0, 1'b0, 5'd3, {2'b11, 8'hFF, 1'b0}, 10, 3);

        repeat (10) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
